panel_shifter: RTL and testbench

PANEL_SHIFTER -- requirements
Module: panel_shifter

---
 rtl/panel_shifter_if.sv | 27 ++
 rtl/panel_shifter.sv | 117 +++++++++++
 tb/tb_panel_shifter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/panel_shifter_if.sv
// panel_shifter_if: row load handshake and panel drive signals for panel_shifter.
interface panel_shifter_if #(
    parameter int row_w = 32,
    parameter int col_w = 16,
    parameter int addr_w = 4
);
    logic row_ready;
    logic [row_w-1:0] row;
    logic [col_w-1:0] col_select;
    logic panel_clk;
    logic panel_data;
    logic panel_lat;
    logic panel_oe_n;
    logic [addr_w-1:0] row_addr;
    logic busy;
    logic overrun;

    modport master (
        output row_ready, row, col_select,
        input panel_clk, panel_data, panel_lat, panel_oe_n, row_addr, busy, overrun
    );

    modport slave (
        input row_ready, row, col_select,
        output panel_clk, panel_data, panel_lat, panel_oe_n, row_addr, busy, overrun
    );
endinterface

// File: rtl/panel_shifter.sv
// panel_shifter: serialises a row to an LED panel, then latches and displays it.
// Defining PANEL_SHIFTER_PENDING_EN adds a one-deep pending row buffer.
module panel_shifter #(
    parameter int row_w = 32,
    parameter int col_w = 16,
    parameter int addr_w = 4,
    parameter int disp_cyc = 64
) (
    input logic clk,
    input logic rst,
    panel_shifter_if.slave bus
);
    localparam int bw = $clog2(2 * row_w);
    localparam int dw = $clog2(disp_cyc + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t state, state_nx;
    logic [row_w-1:0] sr, ld_row;
    logic [addr_w-1:0] addr, row_addr_q, ld_addr;
    logic [bw-1:0] bit_cnt;
    logic [dw-1:0] disp_cnt;
    logic overrun_q, bit_last, disp_last, busy, load, drop;

    function automatic logic [addr_w-1:0] enc(input logic [col_w-1:0] s);
        logic [addr_w-1:0] a;
        a = '0;
        for (int i = col_w - 1; i >= 0; i--)
            if (s[i]) a = addr_w'(i);
        return a;
    endfunction

    assign bit_last = bit_cnt == bw'(2 * row_w - 1);
    assign disp_last = disp_cnt == dw'(disp_cyc - 1);
    assign busy = state != IDLE;

`ifdef PANEL_SHIFTER_PENDING_EN
    logic pend_v, direct, take_pend, store;
    logic [row_w-1:0] pend_row;
    logic [addr_w-1:0] pend_addr;

    // A row arriving on the last display cycle with nothing pending starts straight away.
    assign direct = state == DISPLAY && disp_last && !pend_v;
    assign take_pend = state == DISPLAY && disp_last && pend_v;
    assign load = take_pend || (bus.row_ready && (state == IDLE || direct));
    assign store = bus.row_ready && busy && !pend_v && !direct;
    assign drop = bus.row_ready && busy && pend_v;
    assign ld_row = take_pend ? pend_row : bus.row;
    assign ld_addr = take_pend ? pend_addr : enc(bus.col_select);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v <= 1'b0;
            pend_row <= '0;
            pend_addr <= '0;
        end else if (store) begin
            pend_v <= 1'b1;
            pend_row <= bus.row;
            pend_addr <= enc(bus.col_select);
        end else if (take_pend) begin
            pend_v <= 1'b0;
        end
    end
`else
    assign load = bus.row_ready && state == IDLE;
    assign drop = bus.row_ready && busy;
    assign ld_row = bus.row;
    assign ld_addr = enc(bus.col_select);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = load ? SHIFT : IDLE;
            SHIFT: state_nx = bit_last ? LATCH : SHIFT;
            LATCH: state_nx = DISPLAY;
            DISPLAY: state_nx = disp_last ? (load ? SHIFT : IDLE) : DISPLAY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            addr <= '0;
            row_addr_q <= '0;
            bit_cnt <= '0;
            disp_cnt <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (load) begin
                sr <= ld_row;
                addr <= ld_addr;
            end else if (state == SHIFT && bit_cnt[0]) begin
                sr <= sr << 1;
            end
            bit_cnt <= (state == SHIFT && !bit_last) ? bit_cnt + bw'(1) : '0;
            disp_cnt <= (state == DISPLAY && !disp_last) ? disp_cnt + dw'(1) : '0;
            // Address moves on the edge into LATCH so it is valid during the strobe.
            if (state == SHIFT && bit_last) row_addr_q <= addr;
            if (drop) overrun_q <= 1'b1;
        end
    end

    assign bus.panel_clk = state == SHIFT && bit_cnt[0];
    assign bus.panel_data = state == SHIFT && sr[row_w-1];
    assign bus.panel_lat = state == LATCH;
    assign bus.panel_oe_n = state != DISPLAY;
    assign bus.row_addr = row_addr_q;
    assign bus.busy = busy;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_panel_shifter.sv
// tb_panel_shifter: directed bench with a bit/address scoreboard for panel_shifter.
module tb_panel_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cur = 0;
    bit mon_bits = 1'b1;
    logic prev_clk = 1'b0;
    logic exp_bits[$];
    logic [3:0] exp_addr[$];

    panel_shifter_if #(.row_w(32), .col_w(16), .addr_w(4)) bus ();

    panel_shifter #(.row_w(32), .col_w(16), .addr_w(4), .disp_cyc(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] enc(input logic [15:0] s);
        for (int i = 0; i < 16; i++)
            if (s[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_outs(input string tag);
        chk({tag, "_clk"}, 32'(bus.panel_clk), 0);
        chk({tag, "_data"}, 32'(bus.panel_data), 0);
        chk({tag, "_lat"}, 32'(bus.panel_lat), 0);
        chk({tag, "_oe_n"}, 32'(bus.panel_oe_n), 1);
        chk({tag, "_addr"}, 32'(bus.row_addr), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ovr"}, 32'(bus.overrun), 0);
    endtask

    task automatic send(input logic [31:0] r, input logic [15:0] s, input bit accept);
        @(posedge clk);
        #1;
        bus.row_ready = 1'b1;
        bus.row = r;
        bus.col_select = s;
        if (accept) begin
            for (int i = 31; i >= 0; i--) exp_bits.push_back(r[i]);
            exp_addr.push_back(enc(s));
        end
        @(posedge clk);
        #1;
        bus.row_ready = 1'b0;
        cur += 2;
    endtask

    task automatic goto(input int n);
        repeat (n - cur) @(posedge clk);
        cur = n;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(bus.busy), 0);
    endtask

    // Scoreboard: serial bits on each panel clock rise, address on each latch strobe.
    always @(negedge clk) begin
        if (mon_bits && bus.panel_clk && !prev_clk) begin
            chk("bit_unexpected", 32'(exp_bits.size() != 0), 1);
            if (exp_bits.size() != 0) chk("bit", 32'(bus.panel_data), 32'(exp_bits.pop_front()));
        end
        prev_clk <= bus.panel_clk;
        if (bus.panel_lat) begin
            chk("lat_unexpected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) chk("lat_addr", 32'(bus.row_addr), 32'(exp_addr.pop_front()));
            chk("lat_oe_n", 32'(bus.panel_oe_n), 1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.row_ready = 1'b1;
        bus.row = 32'hFFFF_FFFF;
        bus.col_select = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.row_ready = 1'b0;
        @(negedge clk);
        reset_outs("rst");

        send(32'hF0F0_F0F0, 16'h0004, 1'b1);
        cur = 1;
        goto(1);
        chk("c1_busy", 32'(bus.busy), 1);
        chk("c1_clk", 32'(bus.panel_clk), 0);
        chk("c1_data", 32'(bus.panel_data), 1);
        goto(64);
        chk("c64_clk", 32'(bus.panel_clk), 1);
        chk("c64_lat", 32'(bus.panel_lat), 0);
        chk("c64_addr", 32'(bus.row_addr), 0);
        goto(65);
        chk("c65_lat", 32'(bus.panel_lat), 1);
        chk("c65_addr", 32'(bus.row_addr), 2);
        goto(66);
        chk("c66_oe_n", 32'(bus.panel_oe_n), 0);
        chk("c66_lat", 32'(bus.panel_lat), 0);
        goto(129);
        chk("c129_oe_n", 32'(bus.panel_oe_n), 0);
        chk("c129_busy", 32'(bus.busy), 1);
        goto(130);
        chk("c130_oe_n", 32'(bus.panel_oe_n), 1);
        chk("c130_busy", 32'(bus.busy), 0);

        send(32'h1234_5678, 16'h0000, 1'b1);
        wait_idle();
        chk("sel0_addr", 32'(bus.row_addr), 0);
        send(32'h8001_7FFE, 16'h0006, 1'b1);
        wait_idle();
        chk("sel6_addr", 32'(bus.row_addr), 1);

        for (int k = 0; k < 16; k++) begin
            send($urandom, 16'(1 << k), 1'b1);
            wait_idle();
            chk("walk_addr", 32'(bus.row_addr), 32'(k));
        end
        chk("walk_ovr", 32'(bus.overrun), 0);

        send(32'hA5C3_3C5A, 16'h0010, 1'b1);
        cur = 1;
        goto(10);
        chk("pre_ovr", 32'(bus.overrun), 0);
`ifdef PANEL_SHIFTER_PENDING_EN
        send(32'h0F0F_0F0F, 16'h0100, 1'b1);
        goto(12);
        chk("pend_ovr", 32'(bus.overrun), 0);
        goto(20);
        send(32'hDEAD_BEEF, 16'h0200, 1'b0);
        goto(22);
        chk("full_ovr", 32'(bus.overrun), 1);
        goto(130);
        chk("b2b_busy", 32'(bus.busy), 1);
        chk("b2b_clk", 32'(bus.panel_clk), 0);
        goto(131);
        chk("b2b_clk_hi", 32'(bus.panel_clk), 1);
`else
        send(32'h0F0F_0F0F, 16'h0100, 1'b0);
        goto(12);
        chk("drop_ovr", 32'(bus.overrun), 1);
        goto(130);
        chk("drop_busy", 32'(bus.busy), 0);
        goto(140);
        chk("drop_idle", 32'(bus.busy), 0);
        chk("drop_addr", 32'(bus.row_addr), 4);
`endif
        wait_idle();

        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ovr_clear", 32'(bus.overrun), 0);
        chk("addr_clear", 32'(bus.row_addr), 0);

        mon_bits = 1'b0;
        send(32'hFFFF_0000, 16'h0008, 1'b0);
        cur = 1;
        goto(19);
        chk("mid_busy", 32'(bus.busy), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        cur = 20;
        goto(21);
        reset_outs("midrst");
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("midrst_idle", 32'(bus.busy), 0);
        mon_bits = 1'b1;

        chk("bits_left", 32'(exp_bits.size()), 0);
        chk("addr_left", 32'(exp_addr.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
